// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: steps an active-low column strobe, debounces row presses
// and releases, and keeps a four-digit history of accepted keys for a hex display.
module keypad_scanner #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_hex,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t             r_state, w_state_next;
    logic [3:0]         r_sync1, r_sync2;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_col, w_col_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [3:0]         r_pat;
    logic [1:0]         r_row, w_row_idx, w_key_row;
    logic               w_tick, w_one_low, w_capture, w_accept;
    logic [3:0]         w_key;

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: map_key = 4'h1;  4'h1: map_key = 4'h2;  4'h2: map_key = 4'h3;  4'h3: map_key = 4'hA;
            4'h4: map_key = 4'h4;  4'h5: map_key = 4'h5;  4'h6: map_key = 4'h6;  4'h7: map_key = 4'hB;
            4'h8: map_key = 4'h7;  4'h9: map_key = 4'h8;  4'hA: map_key = 4'h9;  4'hB: map_key = 4'hC;
            4'hC: map_key = 4'h0;  4'hD: map_key = 4'hF;  4'hE: map_key = 4'hE;  default: map_key = 4'hD;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
            r_div   <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign w_tick    = (r_div == DIV_LAST);
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_comb begin
        w_one_low = 1'b1;
        w_row_idx = 2'd0;
        case (r_sync2)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_one_low) begin
                        w_capture  = 1'b1;
                        w_cnt_next = CNT_ONE;
                        if (DEBOUNCE <= 1) begin
                            w_state_next = HELD;
                            w_accept     = 1'b1;
                        end else begin
                            w_state_next = DEB_PRESS;
                        end
                    end else begin
                        w_col_next = r_col + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (r_sync2 == r_pat) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc >= DEB_N) begin
                            w_state_next = HELD;
                            w_accept     = 1'b1;
                        end
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = SCAN;
                        w_col_next   = r_col + 2'd1;
                    end
                end
                HELD: begin
                    if (r_sync2 == 4'hF) begin
                        w_cnt_next = CNT_ONE;
                        if (DEBOUNCE <= 1) begin
                            w_state_next = SCAN;
                            w_col_next   = r_col + 2'd1;
                        end else begin
                            w_state_next = DEB_REL;
                        end
                    end
                end
                default: begin
                    if (r_sync2 == 4'hF) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc >= DEB_N) begin
                            w_state_next = SCAN;
                            w_col_next   = r_col + 2'd1;
                        end
                    end else begin
                        w_state_next = HELD;
                    end
                end
            endcase
        end
    end

    // With single-sample debounce the key is accepted on the capturing tick itself.
    assign w_key_row = (r_state == SCAN) ? w_row_idx : r_row;
    assign w_key     = map_key(w_key_row, r_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SCAN;
            r_col     <= 2'd0;
            r_cnt     <= '0;
            r_pat     <= 4'hF;
            r_row     <= 2'd0;
            key_hex   <= 4'h0;
            key_valid <= 1'b0;
            digits    <= 16'h0000;
        end else begin
            r_state   <= w_state_next;
            r_col     <= w_col_next;
            r_cnt     <= w_cnt_next;
            key_valid <= w_accept;
            if (w_capture) begin
                r_pat <= r_sync2;
                r_row <= w_row_idx;
            end
            if (w_accept) begin
                key_hex <= w_key;
                digits  <= {digits[11:0], w_key};
            end
        end
    end

    assign col_out  = ~(4'b0001 << r_col);
    assign key_held = (r_state == HELD) || (r_state == DEB_REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model pulls rows low when their column
// is strobed; table-driven presses plus bounce, multi-key and reset-during-hold sequences.
module tb_keypad_scanner;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_hex;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    logic [3:0]  key_mask [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_count = 0;

    typedef struct {
        int          r;
        int          c;
        logic [3:0]  exp_hex;
        logic [15:0] exp_digits;
    } vec_t;

    vec_t vecs [6];

    keypad_scanner #(.CLK_HZ(40), .SCAN_HZ(10), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_hex(key_hex), .key_valid(key_valid), .key_held(key_held), .digits(digits)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_out[c]) row_in = row_in & ~key_mask[c];
    end

    always @(negedge clk) if (key_valid === 1'b1) valid_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'b0001 << c;
        return ~p;
    endfunction

    task automatic wait_col_change(output int n, output bit ok);
        logic [3:0] prev;
        prev = col_out;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (col_out != prev) ok = 1'b1;
        end
    endtask

    task automatic wait_col_is(input logic [3:0] target, output bit ok);
        int n;
        bit step_ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            wait_col_change(n, step_ok);
            if (step_ok && col_out == target) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            n++;
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, v0;
        bit ok;
        logic [3:0] seq [5];

        vecs[0] = '{r: 1, c: 2, exp_hex: 4'h6, exp_digits: 16'h0006};
        vecs[1] = '{r: 0, c: 0, exp_hex: 4'h1, exp_digits: 16'h0061};
        vecs[2] = '{r: 0, c: 3, exp_hex: 4'hA, exp_digits: 16'h061A};
        vecs[3] = '{r: 3, c: 0, exp_hex: 4'h0, exp_digits: 16'h61A0};
        vecs[4] = '{r: 3, c: 3, exp_hex: 4'hD, exp_digits: 16'h1A0D};
        vecs[5] = '{r: 3, c: 1, exp_hex: 4'hF, exp_digits: 16'hA0DF};
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110; seq[4] = 4'b1101;

        for (int c = 0; c < 4; c++) key_mask[c] = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_hex", key_hex, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_digits", digits, 16'h0000);
        rst = 1'b0;
        check("idle_start_col", col_out, 4'b1110);

        // Idle scan: one column step per tick, wrapping 3 -> 0.
        for (int i = 0; i < 5; i++) begin
            wait_col_change(n, ok);
            check("idle_col_step_seen", ok, 1'b1);
            check($sformatf("idle_col_%0d", i), col_out, seq[i]);
            if (i > 0) check($sformatf("idle_col_gap_%0d", i), n, TICK_DIV);
        end
        check("idle_no_valid", valid_count, 0);

        // Table of clean presses, each held with a second key added, then released.
        for (int v = 0; v < 6; v++) begin
            v0 = valid_count;
            key_mask[vecs[v].c] = 4'(1 << vecs[v].r);
            wait_valid(60, n, ok);
            check($sformatf("v%0d_valid_seen", v), ok, 1'b1);
            check($sformatf("v%0d_latency n=%0d", v, n), n <= (4 + DEB) * TICK_DIV + 3, 1'b1);
            check($sformatf("v%0d_key_hex", v), key_hex, vecs[v].exp_hex);
            check($sformatf("v%0d_digits", v), digits, vecs[v].exp_digits);
            check($sformatf("v%0d_held", v), key_held, 1'b1);
            key_mask[vecs[v].c] = key_mask[vecs[v].c] | 4'(1 << ((vecs[v].r + 1) % 4));
            repeat (3 * TICK_DIV) @(negedge clk);
            key_mask[vecs[v].c] = 4'(1 << vecs[v].r);
            repeat (TICK_DIV) @(negedge clk);
            check($sformatf("v%0d_still_held", v), key_held, 1'b1);
            check($sformatf("v%0d_single_pulse", v), valid_count, v0 + 1);
            check($sformatf("v%0d_hex_kept", v), key_hex, vecs[v].exp_hex);
            key_mask[vecs[v].c] = 4'h0;
            n  = 0;
            ok = 1'b0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                n++;
                if (!key_held) ok = 1'b1;
            end
            check($sformatf("v%0d_release_seen", v), ok, 1'b1);
            check($sformatf("v%0d_release_time n=%0d", v, n),
                  (n >= 2 * TICK_DIV - 1) && (n <= 3 * TICK_DIV - 1), 1'b1);
            check($sformatf("v%0d_col_advanced", v), col_out, col_pat((vecs[v].c + 1) % 4));
        end

        // Bounce: row low for exactly one tick in column 1.
        v0 = valid_count;
        wait_col_is(4'b1101, ok);
        check("bounce_col_found", ok, 1'b1);
        key_mask[1] = 4'b0100;
        repeat (TICK_DIV) @(negedge clk);
        check("bounce_col_frozen", col_out, 4'b1101);
        key_mask[1] = 4'h0;
        repeat (TICK_DIV) @(negedge clk);
        check("bounce_col_advanced", col_out, 4'b1011);
        check("bounce_not_held", key_held, 1'b0);
        check("bounce_no_valid", valid_count, v0);

        // Two rows low in column 3: ignored, scan keeps wrapping.
        key_mask[3] = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            wait_col_is(4'b0111, ok);
            check($sformatf("multi_col3_found_%0d", k), ok, 1'b1);
            wait_col_change(n, ok);
            check($sformatf("multi_wrap_col_%0d", k), col_out, 4'b1110);
            check($sformatf("multi_wrap_gap_%0d", k), n, TICK_DIV);
        end
        key_mask[3] = 4'h0;
        check("multi_no_valid", valid_count, v0);
        check("multi_not_held", key_held, 1'b0);

        // Reset while a key is held.
        key_mask[1] = 4'b0010;
        wait_valid(60, n, ok);
        check("rh_valid_seen", ok, 1'b1);
        check("rh_key_hex", key_hex, 4'h5);
        check("rh_digits", digits, 16'h0DF5);
        repeat (2) @(negedge clk);
        v0  = valid_count;
        rst = 1'b1;
        #1;
        check("rh_held_cleared", key_held, 1'b0);
        check("rh_col_out", col_out, 4'b1110);
        check("rh_key_hex_cleared", key_hex, 4'h0);
        check("rh_digits_cleared", digits, 16'h0000);
        check("rh_valid_low", key_valid, 1'b0);
        repeat (2) @(negedge clk);
        key_mask[1] = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        check("rh_restart_col0", col_out, 4'b1110);
        repeat (3 * TICK_DIV) @(negedge clk);
        check("rh_no_valid_after", valid_count, v0);
        check("rh_not_held_after", key_held, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
